rca_pipe: RTL and testbench

//  Parametrised, pipelined successor to the combinational ripple-carry adder. Splits a BITS-wide
//  add/subtract into STAGES equal carry-ripple segments, one segment per cycle, with a registered

---
 rtl/rca_pipe.sv | 141 ++++++++++++++
 tb/tb_rca_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: each stage resolves one SEG-bit carry segment,
// with valid/ready handshaking on both sides and full one-op-per-cycle throughput.
module rca_pipe #(
   parameter int BITS   = 32,
   parameter int STAGES = 4
) (
   input  logic            _clk,
   input  logic            _rst_n,
   input  logic            _valid_in,
   output logic            _ready_out,
   input  logic [BITS-1:0] _a_in,
   input  logic [BITS-1:0] _b_in,
   input  logic            _c_in,
   input  logic            _sub_in,
   output logic            _valid_out,
   input  logic            _ready_in,
   output logic [BITS-1:0] _s_out,
   output logic            _c_out,
   output logic            _ovf_out
);

   localparam int SEG = BITS / STAGES;

   if ((STAGES < 1) || ((BITS % STAGES) != 0)) begin : g_bad_params
      $error("rca_pipe: BITS must be a positive multiple of STAGES");
   end

   function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                            input logic cin);
      logic [SEG-1:0] s;
      logic           c;
      c = cin;
      s = '0;
      for (int i = 0; i < SEG; i++) begin
         s[i] = (a[i] ^ b[i]) ^ c;
         c    = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      end
      return {c, s};
   endfunction

   function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   logic [STAGES-1:0] vld_q, vld_d;
   logic [STAGES-1:0] sub_q, sub_d;
   logic [STAGES-1:0] c_q, c_d;
   logic [STAGES-1:0] adv;
   logic [BITS-1:0]   a_q [STAGES];
   logic [BITS-1:0]   a_d [STAGES];
   logic [BITS-1:0]   b_q [STAGES];
   logic [BITS-1:0]   b_d [STAGES];
   logic [BITS-1:0]   s_q [STAGES];
   logic [BITS-1:0]   s_d [STAGES];
   logic              ovf_q, ovf_d;
   logic              load0;
   logic [BITS-1:0]   b_cond;

   always_comb begin
      logic         room;
      logic [SEG:0] r;
      // A stage may move forward when any later slot is free or the output is being taken.
      room = _ready_in;
      adv  = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         adv[k] = vld_q[k] & room;
         room   = room | ~vld_q[k];
      end
      _ready_out = ~vld_q[0] | adv[0];
      load0      = _valid_in & _ready_out;

      vld_d  = vld_q;
      sub_d  = sub_q;
      c_d    = c_q;
      a_d    = a_q;
      b_d    = b_q;
      s_d    = s_q;
      ovf_d  = ovf_q;
      r      = '0;
      b_cond = _sub_in ? ~_b_in : _b_in;

      if (load0) begin
         r                   = seg_add(_a_in[SEG-1:0], b_cond[SEG-1:0], _sub_in ^ _c_in);
         a_d[0]              = _a_in;
         b_d[0]              = b_cond;
         sub_d[0]            = _sub_in;
         c_d[0]              = r[SEG];
         s_d[0]              = '0;
         s_d[0][SEG-1:0]     = r[SEG-1:0];
         if (STAGES == 1) begin
            ovf_d = ovf_of(_a_in[BITS-1], b_cond[BITS-1], s_d[0][BITS-1]);
         end
      end
      vld_d[0] = load0 | (vld_q[0] & ~adv[0]);

      for (int k = 1; k < STAGES; k++) begin
         if (adv[k-1]) begin
            r                     = seg_add(a_q[k-1][k*SEG +: SEG], b_q[k-1][k*SEG +: SEG], c_q[k-1]);
            a_d[k]                = a_q[k-1];
            b_d[k]                = b_q[k-1];
            sub_d[k]              = sub_q[k-1];
            c_d[k]                = r[SEG];
            s_d[k]                = s_q[k-1];
            s_d[k][k*SEG +: SEG]  = r[SEG-1:0];
            if (k == STAGES - 1) begin
               ovf_d = ovf_of(a_q[k-1][BITS-1], b_q[k-1][BITS-1], s_d[k][BITS-1]);
            end
         end
         vld_d[k] = adv[k-1] | (vld_q[k] & ~adv[k]);
      end
   end

   always_ff @(posedge _clk or negedge _rst_n) begin
      if (!_rst_n) begin
         vld_q <= '0;
         sub_q <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         sub_q <= sub_d;
         c_q   <= c_d;
         ovf_q <= ovf_d;
         a_q   <= a_d;
         b_q   <= b_d;
         s_q   <= s_d;
      end
   end

   // Raw carry of the final segment becomes a borrow in subtract mode.
   assign _valid_out = vld_q[STAGES-1];
   assign _s_out     = s_q[STAGES-1];
   assign _c_out     = c_q[STAGES-1] ^ sub_q[STAGES-1];
   assign _ovf_out   = ovf_q;

endmodule

// File: tb/tb_rca_pipe.sv
// Scoreboard bench for rca_pipe: a 32-bit/4-stage instance and an 8-bit/1-stage instance.
module tb_rca_pipe;

   typedef struct packed {
      logic [63:0] s;
      logic        c;
      logic        o;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0, ready_out, valid_out, ready_in = 1'b1;
   logic [31:0] a_in = '0, b_in = '0, s_out;
   logic        c_in = 1'b0, sub_in = 1'b0, c_out, ovf_out;

   logic        valid_in8 = 1'b0, ready_out8, valid_out8, ready_in8 = 1'b1;
   logic [7:0]  a8 = '0, b8 = '0, s_out8;
   logic        c8 = 1'b0, sub8 = 1'b0, c_out8, ovf_out8;

   int   checks = 0;
   int   passes = 0;
   bit   strict = 1'b0;
   bit   rand_rdy = 1'b0;
   exp_t sb[$];
   exp_t sb8[$];

   rca_pipe #(.BITS(32), .STAGES(4)) u_dut (
      ._clk(clk), ._rst_n(rst_n), ._valid_in(valid_in), ._ready_out(ready_out),
      ._a_in(a_in), ._b_in(b_in), ._c_in(c_in), ._sub_in(sub_in),
      ._valid_out(valid_out), ._ready_in(ready_in), ._s_out(s_out),
      ._c_out(c_out), ._ovf_out(ovf_out)
   );

   rca_pipe #(.BITS(8), .STAGES(1)) u_dut8 (
      ._clk(clk), ._rst_n(rst_n), ._valid_in(valid_in8), ._ready_out(ready_out8),
      ._a_in(a8), ._b_in(b8), ._c_in(c8), ._sub_in(sub8),
      ._valid_out(valid_out8), ._ready_in(ready_in8), ._s_out(s_out8),
      ._c_out(c_out8), ._ovf_out(ovf_out8)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   function automatic exp_t model(input int w, input logic [63:0] a_i, input logic [63:0] b_i,
                                  input logic c, input logic sub);
      logic [64:0] t;
      logic [63:0] mask, a, b;
      exp_t        e;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      a    = a_i & mask;
      b    = b_i & mask;
      if (sub) t = {1'b0, a} - {1'b0, b} - 65'(c);
      else     t = {1'b0, a} + {1'b0, b} + 65'(c);
      e.s = t[63:0] & mask;
      e.c = t[w];
      if (sub) e.o = (a[w-1] != b[w-1]) && (e.s[w-1] != a[w-1]);
      else     e.o = (a[w-1] == b[w-1]) && (e.s[w-1] != a[w-1]);
      return e;
   endfunction

   function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o);
      exp_t e;
      e.s = s;
      e.c = c;
      e.o = o;
      return e;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the transfer edge with valid_in low.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, input logic sub,
                       input exp_t e);
      int n;
      a_in = a; b_in = b; c_in = c; sub_in = sub; valid_in = 1'b1;
      n = 0;
      @(negedge clk);
      if (strict) chk("stream_ready_out", 64'(ready_out), 64'd1);
      while (!ready_out && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!ready_out) begin
         $display("FAIL send_timeout: ready_out=0 for %0d cycles, required 1", n);
         checks++;
         valid_in = 1'b0;
         return;
      end
      sb.push_back(e);
      @(posedge clk); #1;
      valid_in = 1'b0;
   endtask

   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sub,
                        input exp_t e);
      a8 = a; b8 = b; c8 = c; sub8 = sub; valid_in8 = 1'b1;
      @(negedge clk);
      chk("ready_out8", 64'(ready_out8), 64'd1);
      if (ready_out8) sb8.push_back(e);
      @(posedge clk); #1;
      valid_in8 = 1'b0;
   endtask

   task automatic lat_check(input string name, input int exp);
      int lat;
      lat = 1;
      @(negedge clk);
      while (!valid_out && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk(name, 64'(lat), 64'(exp));
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || sb8.size() != 0) && n < 300) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk); #1;
      chk("drain_sb_empty", 64'(sb.size()), 64'd0);
   endtask

   // Monitor for the 32-bit instance: pops on each output transfer, checks stability while stalled.
   initial begin : mon
      bit          hold;
      logic [31:0] hs;
      logic        hc, ho;
      exp_t        e;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
            continue;
         end
         if (hold) begin
            chk("stall_valid_out", 64'(valid_out), 64'd1);
            chk("stall_s_out", 64'(s_out), 64'(hs));
            chk("stall_c_out", 64'(c_out), 64'(hc));
            chk("stall_ovf_out", 64'(ovf_out), 64'(ho));
         end
         hold = 1'b0;
         if (valid_out && ready_in) begin
            if (sb.size() == 0) begin
               $display("FAIL unexpected_result: s_out=0x%0h appeared, required no result", s_out);
               checks++;
            end else begin
               e = sb.pop_front();
               chk("s_out", 64'(s_out), e.s);
               chk("c_out", 64'(c_out), 64'(e.c));
               chk("ovf_out", 64'(ovf_out), 64'(e.o));
            end
         end else if (valid_out) begin
            hold = 1'b1;
            hs = s_out; hc = c_out; ho = ovf_out;
         end
      end
   end

   initial begin : mon8
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && valid_out8) begin
            if (sb8.size() == 0) begin
               $display("FAIL unexpected_result8: s_out8=0x%0h appeared, required no result", s_out8);
               checks++;
            end else begin
               e = sb8.pop_front();
               chk("s_out8", 64'(s_out8), e.s);
               chk("c_out8", 64'(c_out8), 64'(e.c));
               chk("ovf_out8", 64'(ovf_out8), 64'(e.o));
            end
         end
      end
   end

   initial begin : rdy_gen
      forever begin
         @(posedge clk); #1;
         if (rand_rdy) ready_in = 1'($urandom_range(0, 1));
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] ra, rb;
      logic        rc, rs;
      logic [31:0] bpa [8];
      logic [31:0] bpb [8];
      logic        bpc [8];
      logic        bps [8];
      int          acc, idx;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid_out", 64'(valid_out), 64'd0);
      chk("rst_s_out", 64'(s_out), 64'd0);
      chk("rst_c_out", 64'(c_out), 64'd0);
      chk("rst_ovf_out", 64'(ovf_out), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("idle_ready_out", 64'(ready_out), 64'd1);
      @(posedge clk); #1;

      // 8-bit single-stage instance
      send8(8'hFF, 8'h01, 1'b0, 1'b0, mk(64'h00, 1'b1, 1'b0));
      @(negedge clk);
      chk("lat8", 64'(valid_out8), 64'd1);
      @(posedge clk); #1;
      send8(8'h7F, 8'h01, 1'b0, 1'b0, mk(64'h80, 1'b0, 1'b1));
      send8(8'h00, 8'h01, 1'b0, 1'b1, mk(64'hFF, 1'b1, 1'b0));
      send8(8'h80, 8'h01, 1'b0, 1'b1, mk(64'h7F, 1'b0, 1'b1));
      for (int i = 0; i < 20; i++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
         send8(ra[7:0], rb[7:0], rc, rs, model(8, 64'(ra[7:0]), 64'(rb[7:0]), rc, rs));
      end
      repeat (2) @(posedge clk); #1;
      chk("sb8_empty", 64'(sb8.size()), 64'd0);

      // Carry through every segment boundary, with latency
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(64'h0, 1'b1, 1'b0));
      lat_check("latency", 4);
      drain();

      // Directed vectors, back to back
      send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, mk(64'hFFFF_FFFE, 1'b1, 1'b0));
      send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(64'h7FFF_FFFF, 1'b0, 1'b1));
      send(32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, mk(64'hFFFF_FFFF, 1'b1, 1'b0));
      send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, mk(64'h8000_0000, 1'b0, 1'b1));
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, mk(64'h0000_0100, 1'b0, 1'b0));
      send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, mk(64'h0, 1'b0, 1'b0));
      drain();

      // Streaming with ready_in held high
      strict = 1'b1;
      for (int i = 0; i < 100; i++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
         send(ra, rb, rc, rs, model(32, 64'(ra), 64'(rb), rc, rs));
      end
      strict = 1'b0;
      repeat (4) @(posedge clk); #1;
      chk("stream_no_bubbles", 64'(sb.size()), 64'd0);
      drain();

      // Back-pressure: ten cycles of ready_in low
      for (int i = 0; i < 8; i++) begin
         bpa[i] = $urandom; bpb[i] = $urandom;
         bpc[i] = 1'($urandom_range(0, 1)); bps[i] = 1'($urandom_range(0, 1));
      end
      ready_in = 1'b0;
      acc = 0;
      idx = 0;
      a_in = bpa[0]; b_in = bpb[0]; c_in = bpc[0]; sub_in = bps[0]; valid_in = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (ready_out && idx < 8) begin
            sb.push_back(model(32, 64'(bpa[idx]), 64'(bpb[idx]), bpc[idx], bps[idx]));
            acc++;
            idx++;
         end
         @(posedge clk); #1;
         if (idx < 8) begin
            a_in = bpa[idx]; b_in = bpb[idx]; c_in = bpc[idx]; sub_in = bps[idx];
         end
      end
      valid_in = 1'b0;
      chk("bp_accepted", 64'(acc), 64'd4);
      chk("bp_ready_out_low", 64'(ready_out), 64'd0);
      ready_in = 1'b1;
      while (idx < 8) begin
         send(bpa[idx], bpb[idx], bpc[idx], bps[idx],
              model(32, 64'(bpa[idx]), 64'(bpb[idx]), bpc[idx], bps[idx]));
         idx++;
      end
      drain();

      // Random 50% back-pressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
         send(ra, rb, rc, rs, model(32, 64'(ra), 64'(rb), rc, rs));
      end
      rand_rdy = 1'b0;
      ready_in = 1'b1;
      drain();

      // Reset with three operations in flight
      ready_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ra = $urandom; rb = $urandom;
         send(ra, rb, 1'b0, 1'b0, model(32, 64'(ra), 64'(rb), 1'b0, 1'b0));
      end
      @(posedge clk); #3;
      chk("pre_reset_valid_out", 64'(valid_out), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_valid_out", 64'(valid_out), 64'd0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      ready_in = 1'b1;
      send(32'd2, 32'd3, 1'b0, 1'b0, mk(64'd5, 1'b0, 1'b0));
      lat_check("post_reset_latency", 4);
      drain();
      repeat (4) @(posedge clk); #1;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
